// File: rtl/eucl_fetch_if.sv
// Fetch <-> core bus for the eucl GCD core.
//   pm_cont : instruction word at the current PC (fetch -> core)
//   p_c     : current program counter          (fetch -> core)
//   core_en : core may commit state this cycle  (fetch -> core)
//   p_c_out : next PC computed by the core      (core  -> fetch)
interface eucl_fetch_if;
  logic [20:0] pm_cont;
  logic [3:0]  p_c;
  logic        core_en;
  logic [3:0]  p_c_out;

  modport master (output pm_cont, output p_c, output core_en, input p_c_out);
  modport slave  (input pm_cont, input p_c, input core_en, output p_c_out);
endinterface

// File: rtl/eucl_fetch.sv
// Instruction fetch / sequencing stage in front of the eucl GCD core.
// Holds a 16 x 21-bit program memory and the 4-bit PC; the core supplies
// the next PC, and this block decides whether the core may advance.
// Ports:
//   clock, reset_n            : rising-edge clock, async active-low reset
//   load_en/load_addr/load_data : program write port (IDLE/DONE only)
//   start                     : one-cycle pulse that begins a run
//   step_mode, step           : single-step control
//   core                      : fetch <-> core bus (pm_cont, p_c, core_en, p_c_out)
//   running, done, timeout    : run status
//   cycle_count               : enabled cycles of the current/last run
module eucl_fetch #(
  parameter logic [3:0]  START_ADDR = 4'h0,
  parameter logic [3:0]  HALT_ADDR  = 4'hF,
  parameter logic [15:0] MAX_CYCLES = 16'd1000
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         load_en,
  input  logic [3:0]   load_addr,
  input  logic [20:0]  load_data,
  input  logic         start,
  input  logic         step_mode,
  input  logic         step,
  eucl_fetch_if.master core,
  output logic         running,
  output logic         done,
  output logic         timeout,
  output logic [15:0]  cycle_count
);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

  state_t      state_q, state_d;
  logic [20:0] mem [16];
  logic [3:0]  p_c_q;
  logic        core_en_w;
  logic        halt_hit;
  logic        budget_hit;
  logic        launch;

  // Program memory has no reset so a loaded program survives reset_n.
  always_ff @(posedge clock) begin
    if (load_en && (state_q != ST_RUN))
      mem[load_addr] <= load_data;
  end

  assign core.pm_cont = mem[p_c_q];
  assign core.p_c     = p_c_q;
  assign core.core_en = core_en_w;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    core_en_w  = 1'b0;
    running    = 1'b0;
    done       = 1'b0;
    halt_hit   = 1'b0;
    budget_hit = 1'b0;
    launch     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          launch  = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        running   = 1'b1;
        core_en_w = !step_mode || step;
        if (core_en_w) begin
          halt_hit   = (core.p_c_out == HALT_ADDR);
          // Halt takes priority over the budget when both land on one edge.
          budget_hit = !halt_hit && (cycle_count == MAX_CYCLES - 16'd1);
          if (halt_hit || budget_hit) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        done = 1'b1;
        if (start) begin
          launch  = 1'b1;
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      p_c_q       <= '0;
      cycle_count <= '0;
      timeout     <= 1'b0;
    end else if (launch) begin
      p_c_q       <= START_ADDR;
      cycle_count <= '0;
      timeout     <= 1'b0;
    end else if (core_en_w) begin
      p_c_q <= core.p_c_out;
      if (cycle_count != '1) cycle_count <= cycle_count + 16'd1;
      if (budget_hit) timeout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_eucl_fetch.sv
// Scoreboard bench for eucl_fetch: three instances (default budget, budget 8,
// budget 4). Stimulus pushes the expected PC/count (and optionally the
// instruction word) for every cycle the core should be enabled; a monitor pops
// one entry per observed core_en pulse. Status is checked with direct probes.
module tb_eucl_fetch;

  localparam logic [20:0] WORD_A = 21'b010101000110000000010;
  localparam logic [20:0] WORD_B = 21'b010101000110000001010;
  localparam logic [20:0] WORD_C = 21'h1F0F0F;
  localparam logic [20:0] WORD_D = 21'h0ABCDE;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        load_en;
  logic [3:0]  load_addr;
  logic [20:0] load_data;
  logic        start0, start8, start4;
  logic        step_mode, step;
  logic        running0, done0, timeout0;
  logic        running8, done8, timeout8;
  logic        running4, done4, timeout4;
  logic [15:0] cnt0, cnt8, cnt4;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    int          inst;
    logic [3:0]  pc;
    logic [15:0] cnt;
    bit          pm_chk;
    logic [20:0] pm;
  } exp_t;
  exp_t exp_q[$];

  eucl_fetch_if bus0 ();
  eucl_fetch_if bus8 ();
  eucl_fetch_if bus4 ();

  eucl_fetch u0 (
    .clock(clock), .reset_n(reset_n), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .start(start0), .step_mode(step_mode), .step(step),
    .core(bus0), .running(running0), .done(done0), .timeout(timeout0),
    .cycle_count(cnt0)
  );

  eucl_fetch #(.MAX_CYCLES(16'd8)) u8 (
    .clock(clock), .reset_n(reset_n), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .start(start8), .step_mode(step_mode), .step(step),
    .core(bus8), .running(running8), .done(done8), .timeout(timeout8),
    .cycle_count(cnt8)
  );

  eucl_fetch #(.MAX_CYCLES(16'd4)) u4 (
    .clock(clock), .reset_n(reset_n), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .start(start4), .step_mode(step_mode), .step(step),
    .core(bus4), .running(running4), .done(done4), .timeout(timeout4),
    .cycle_count(cnt4)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input int inst, input logic [3:0] pc, input logic [15:0] cnt,
                      input bit pm_chk, input logic [20:0] pm);
    exp_t e;
    e.inst = inst; e.pc = pc; e.cnt = cnt; e.pm_chk = pm_chk; e.pm = pm;
    exp_q.push_back(e);
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic mon_pop(input int inst, input logic [3:0] pc, input logic [15:0] cnt,
                         input logic [20:0] pm);
    exp_t e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL enable_inst%0d: unexpected core_en at pc=%0h cnt=%0d", inst, pc, cnt);
    end else begin
      e = exp_q.pop_front();
      if (e.inst != inst || e.pc !== pc || e.cnt !== cnt || (e.pm_chk && e.pm !== pm)) begin
        n_err++;
        $display("FAIL enable_inst%0d: got inst=%0d pc=%0h cnt=%0d pm=%0h expected inst=%0d pc=%0h cnt=%0d pm=%0h",
                 inst, inst, pc, cnt, pm, e.inst, e.pc, e.cnt, e.pm);
      end
    end
  endtask

  // Monitor: one scoreboard entry per enabled core cycle, sampled mid-cycle.
  always @(negedge clock) begin
    if (bus0.core_en === 1'b1) mon_pop(0, bus0.p_c, cnt0, bus0.pm_cont);
    if (bus8.core_en === 1'b1) mon_pop(8, bus8.p_c, cnt8, bus8.pm_cont);
    if (bus4.core_en === 1'b1) mon_pop(4, bus4.p_c, cnt4, bus4.pm_cont);
  end

  logic [3:0] seq2 [6];
  logic [3:0] m_pc;
  logic [15:0] m_cnt;

  initial begin
    reset_n = 1'b0; load_en = 1'b0; load_addr = '0; load_data = '0;
    start0 = 1'b0; start8 = 1'b0; start4 = 1'b0; step_mode = 1'b0; step = 1'b0;
    bus0.p_c_out = '0; bus8.p_c_out = '0; bus4.p_c_out = '0;
    seq2[0] = 4'h1; seq2[1] = 4'h2; seq2[2] = 4'h2;
    seq2[3] = 4'h2; seq2[4] = 4'h3; seq2[5] = 4'hF;
    tick; tick;
    reset_n = 1'b1;
    tick;

    // Reset state
    chk("rst_pc", 32'(bus0.p_c), 32'h0);
    chk("rst_core_en", 32'(bus0.core_en), 32'h0);
    chk("rst_running", 32'(running0), 32'h0);
    chk("rst_done", 32'(done0), 32'h0);
    chk("rst_timeout", 32'(timeout0), 32'h0);
    chk("rst_cnt", 32'(cnt0), 32'h0);

    // 1. Load path and retention across reset
    load_en = 1'b1; load_addr = 4'h0; load_data = WORD_A;
    tick;
    load_addr = 4'h1; load_data = WORD_B;
    tick;
    load_en = 1'b0;
    chk("load_pm0", 32'(bus0.pm_cont), 32'(WORD_A));
    #2 reset_n = 1'b0;
    #2 reset_n = 1'b1;
    tick;
    chk("retain_pm0", 32'(bus0.pm_cont), 32'(WORD_A));

    // 2. Free run: 1,2,2,2,3,F
    start0 = 1'b1;
    tick;
    start0 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      m_pc = (i == 0) ? 4'h0 : seq2[i-1];
      push(0, m_pc, 16'(i), (i < 2), (i == 0) ? WORD_A : WORD_B);
      bus0.p_c_out = seq2[i];
      tick;
    end
    chk("free_done", 32'(done0), 32'h1);
    chk("free_pc", 32'(bus0.p_c), 32'hF);
    chk("free_cnt", 32'(cnt0), 32'd6);
    chk("free_timeout", 32'(timeout0), 32'h0);
    chk("free_core_en", 32'(bus0.core_en), 32'h0);
    chk("free_running", 32'(running0), 32'h0);

    // 3. Single step: steps on cycles 2, 5, 8 of 10
    step_mode = 1'b1;
    start0 = 1'b1;
    tick;
    start0 = 1'b0;
    chk("step_done_clr", 32'(done0), 32'h0);
    chk("step_pc_start", 32'(bus0.p_c), 32'h0);
    m_pc = 4'h0; m_cnt = '0;
    for (int i = 0; i < 10; i++) begin
      step = (i == 2 || i == 5 || i == 8);
      bus0.p_c_out = m_pc + 4'h1;
      if (step) push(0, m_pc, m_cnt, 1'b0, '0);
      tick;
      if (step) begin
        m_pc = m_pc + 4'h1;
        m_cnt = m_cnt + 16'd1;
      end
    end
    step = 1'b0;
    chk("step_pc", 32'(bus0.p_c), 32'h3);
    chk("step_cnt", 32'(cnt0), 32'd3);
    chk("step_running", 32'(running0), 32'h1);

    // 6. Async reset mid-run, between edges
    #2 reset_n = 1'b0;
    #1;
    chk("areset_pc", 32'(bus0.p_c), 32'h0);
    chk("areset_running", 32'(running0), 32'h0);
    chk("areset_core_en", 32'(bus0.core_en), 32'h0);
    chk("areset_cnt", 32'(cnt0), 32'h0);
    #1 reset_n = 1'b1;
    tick;
    step_mode = 1'b0;
    start0 = 1'b1;
    tick;
    start0 = 1'b0;
    push(0, 4'h0, 16'd0, 1'b1, WORD_A);
    bus0.p_c_out = 4'hF;
    tick;
    chk("rerun_done", 32'(done0), 32'h1);
    chk("rerun_cnt", 32'(cnt0), 32'd1);

    // 4. Timeout, budget 8, core self-loops at 2
    bus8.p_c_out = 4'h2;
    start8 = 1'b1;
    tick;
    start8 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      push(8, (i == 0) ? 4'h0 : 4'h2, 16'(i), 1'b0, '0);
      tick;
      if (i == 6) chk("tmo_not_yet", 32'(done8), 32'h0);
    end
    chk("tmo_done", 32'(done8), 32'h1);
    chk("tmo_timeout", 32'(timeout8), 32'h1);
    chk("tmo_cnt", 32'(cnt8), 32'd8);
    chk("tmo_pc", 32'(bus8.p_c), 32'h2);

    // 5. Halt/timeout tie at budget 4, with writes attempted during RUN
    bus4.p_c_out = 4'h0;
    start4 = 1'b1;
    tick;
    start4 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      load_en = (i == 0 || i == 1);
      load_addr = 4'h0;
      load_data = WORD_C;
      bus4.p_c_out = (i == 3) ? 4'hF : 4'h0;
      push(4, 4'h0, 16'(i), 1'b1, WORD_A);
      tick;
    end
    load_en = 1'b0;
    chk("tie_done", 32'(done4), 32'h1);
    chk("tie_timeout", 32'(timeout4), 32'h0);
    chk("tie_cnt", 32'(cnt4), 32'd4);
    chk("tie_pc", 32'(bus4.p_c), 32'hF);

    // Simultaneous load and start from DONE: first fetch sees the new word
    load_en = 1'b1; load_addr = 4'h0; load_data = WORD_D;
    start4 = 1'b1;
    tick;
    load_en = 1'b0; start4 = 1'b0;
    chk("ldstart_pc", 32'(bus4.p_c), 32'h0);
    chk("ldstart_pm", 32'(bus4.pm_cont), 32'(WORD_D));
    chk("ldstart_timeout", 32'(timeout4), 32'h0);
    bus4.p_c_out = 4'hF;
    push(4, 4'h0, 16'd0, 1'b1, WORD_D);
    tick;
    chk("ldstart_done", 32'(done4), 32'h1);

    tick;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/eucl_fetch.md
Name: eucl_fetch

Overview:
- Instruction-fetch and sequencing stage directly upstream of the eucl GCD core.
- Holds a 16 x 21-bit program memory and the 4-bit program-counter register.
- Presents `pm_cont` and `p_c` to the core, takes the core's `p_c_out` back as the next PC, and gates core advance with a clock enable.
- Provides program load, start, single-step, halt detection and a cycle-budget timeout.

Parameters:
- START_ADDR, 4'h0, PC value loaded on start.
- HALT_ADDR, 4'hF, next-PC value from the core that terminates a run.
- MAX_CYCLES, 16'd1000, executed-cycle budget before forced timeout halt.

Ports:
- clock  in  1  system clock, rising-edge.
- reset_n  in  1  asynchronous, active-low reset.
- load_en  in  1  program-memory write strobe (honoured in IDLE/DONE only).
- load_addr  in  4  write address.
- load_data  in  21  instruction word to write.
- start  in  1  one-cycle pulse; begins a run.
- step_mode  in  1  1 = advance only on step pulses.
- step  in  1  single-step pulse (used when step_mode=1).
- p_c_out  in  4  next PC from the eucl core.
- pm_cont  out  21  instruction at current PC, to the core.
- p_c  out  4  current PC, to the core.
- core_en  out  1  core may commit state this cycle.
- running  out  1  FSM in RUN.
- done  out  1  run finished (HALT_ADDR reached or timeout).
- timeout  out  1  run ended by MAX_CYCLES budget.
- cycle_count  out  16  executed (core_en=1) cycles of the current/last run.

Behaviour:
- Reset (async, reset_n=0):
  - State = IDLE; p_c = 0; core_en, running, done, timeout = 0; cycle_count = 0.
  - Program memory is NOT cleared; contents survive reset.
- Memory read: pm_cont = mem[p_c], combinational (same-cycle as p_c, zero latency). It always reflects the current p_c, including while stalled.
- Memory write: synchronous at posedge when load_en=1 and state ∈ {IDLE, DONE}. Ignored in RUN.
- FSM states: IDLE, RUN, DONE.
  - IDLE:
    - core_en = 0; p_c holds.
    - start=1 -> RUN; p_c <= START_ADDR; cycle_count <= 0; timeout <= 0.
  - RUN:
    - running = 1.
    - core_en = 1 when step_mode=0, or when step_mode=1 and step=1; otherwise core_en = 0.
    - On a posedge with core_en=1: p_c <= p_c_out and cycle_count <= cycle_count+1.
    - On a posedge with core_en=0: p_c and cycle_count hold.
    - Halt: core_en=1 and p_c_out == HALT_ADDR -> DONE. p_c <= HALT_ADDR and cycle_count increments on that edge.
    - Timeout: core_en=1 and cycle_count == MAX_CYCLES-1 without halt -> DONE; timeout <= 1; p_c <= p_c_out.
    - Halt and timeout on the same edge: halt wins; timeout stays 0.
    - start during RUN: ignored.
  - DONE:
    - done = 1; core_en = 0; p_c and cycle_count hold for readout.
    - start=1 -> RUN with the same initialisation as from IDLE; done and timeout clear on that edge.
- Simultaneous load_en and start in IDLE/DONE:
  - Both take effect on the same edge.
  - The first fetch (at START_ADDR) sees the newly written word if load_addr == START_ADDR.
- Step pulse while step_mode=0: no extra effect. step_mode may change mid-run and takes effect the same cycle.
- PC wrap: p_c is 4 bits and takes p_c_out verbatim; there is no internal increment, hence no overflow.
- cycle_count saturates at 16'hFFFF; it is unreachable with legal MAX_CYCLES ≤ 16'hFFFF.
- Reset mid-run: immediate return to IDLE with all outputs at reset values. A new start re-runs the retained program.

Test Plan:
1. Load path:
   - Stimulus: in IDLE, write mem[0]=21'b010101000110000000010, mem[1]=21'b010101000110000001010; then reset pulse.
   - Required response: with p_c=0, pm_cont=21'b010101000110000000010 both before and after the reset (memory retained).
2. Free run:
   - Stimulus: start; core model returns p_c_out sequence 1,2,2,2,3,HALT_ADDR.
   - Required response: p_c goes 0,1,2,2,2,3,F; done=1 after the 6th edge; cycle_count=6; timeout=0; core_en=0 in DONE.
3. Single step:
   - Stimulus: step_mode=1; start; step pulsed on 3 of 10 cycles; p_c_out=p_c+1.
   - Required response: p_c=3 and cycle_count=3 after the 10 cycles; core_en high only on the 3 step cycles.
4. Timeout:
   - Stimulus: MAX_CYCLES=8; core self-loops (p_c_out=2).
   - Required response: done=1, timeout=1, cycle_count=8, p_c=2 after exactly 8 enabled cycles.
5. Halt/timeout tie and writes during RUN:
   - Stimulus: MAX_CYCLES=4; p_c_out=F on the 4th cycle; load_en asserted during RUN.
   - Required response: timeout=0, done=1; memory unchanged by the RUN-time write.
6. Async reset mid-run:
   - Stimulus: reset_n low between edges during RUN.
   - Required response: p_c=0, running=0, core_en=0 immediately, without waiting for a clock edge; a subsequent start re-executes from START_ADDR.
